// File: rtl/div_tick_scheduler_if.sv
// Control, config handshake and status bundle for div_tick_scheduler.
// sq_out exists only when SQUARE_OUT_EN is defined.
interface div_tick_scheduler_if #(
  parameter int unsigned CW = 8
);
  logic          start;
  logic          stop;
  logic          cfg_valid;
  logic [CW-1:0] cfg_div;
  logic          cfg_ready;
  logic          tick;
  logic          busy;
  logic [CW-1:0] phase;
  logic          err;
`ifdef SQUARE_OUT_EN
  logic          sq_out;

  modport master (
    output start, stop, cfg_valid, cfg_div,
    input  cfg_ready, tick, busy, phase, err, sq_out
  );
  modport slave (
    input  start, stop, cfg_valid, cfg_div,
    output cfg_ready, tick, busy, phase, err, sq_out
  );
`else
  modport master (
    output start, stop, cfg_valid, cfg_div,
    input  cfg_ready, tick, busy, phase, err
  );
  modport slave (
    input  start, stop, cfg_valid, cfg_div,
    output cfg_ready, tick, busy, phase, err
  );
`endif
endinterface

// File: rtl/div_tick_scheduler.sv
// Run-time programmable divide-by-N tick sequencer with deferred divisor update.
// Define SQUARE_OUT_EN to add the registered near-50% duty output sq_out.
module div_tick_scheduler #(
  parameter int unsigned CW          = 8,
  parameter int unsigned DEFAULT_DIV = 3
) (
  input logic                clk,
  input logic                reset,
  div_tick_scheduler_if.slave bus
);

  localparam logic [CW-1:0] DefDiv = CW'(DEFAULT_DIV);

  typedef enum logic [1:0] {StIdle, StRun, StPend} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] phase_q, phase_d;
  logic [CW-1:0] active_div_q, active_div_d;
  logic [CW-1:0] pend_div_q, pend_div_d;
  logic          err_q, err_d;

  logic xfer;
  logic legal;
  logic accept;
  logic wrap;

  assign xfer   = bus.cfg_valid && (state_q != StPend);
  assign legal  = (bus.cfg_div >= CW'(2));
  assign accept = xfer && legal;
  assign wrap   = (phase_q == (active_div_q - CW'(1)));

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    active_div_d = active_div_q;
    pend_div_d   = pend_div_q;
    err_d        = xfer && !legal;
    unique case (state_q)
      StIdle: begin
        phase_d = '0;
        if (accept) begin
          active_div_d = bus.cfg_div;
        end
        if (bus.start && !bus.stop) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (bus.stop) begin
          // Stop beats wrap and config, but a legal divisor still lands.
          state_d = StIdle;
          phase_d = '0;
          if (accept) begin
            active_div_d = bus.cfg_div;
          end
        end else begin
          phase_d = wrap ? '0 : phase_q + CW'(1);
          if (accept) begin
            pend_div_d = bus.cfg_div;
            state_d    = StPend;
          end
        end
      end
      StPend: begin
        if (bus.stop) begin
          state_d      = StIdle;
          phase_d      = '0;
          active_div_d = pend_div_q;
        end else if (wrap) begin
          state_d      = StRun;
          phase_d      = '0;
          active_div_d = pend_div_q;
        end else begin
          phase_d = phase_q + CW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        phase_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      phase_q      <= '0;
      active_div_q <= DefDiv;
      pend_div_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      active_div_q <= active_div_d;
      pend_div_q   <= pend_div_d;
      err_q        <= err_d;
    end
  end

  assign bus.tick      = (state_q != StIdle) && (phase_q == '0);
  assign bus.busy      = (state_q != StIdle);
  assign bus.cfg_ready = (state_q != StPend);
  assign bus.phase     = phase_q;
  assign bus.err       = err_q;

`ifdef SQUARE_OUT_EN
  logic          sq_q, sq_d;
  logic [CW:0]   half_d;

  // Computed from next state so the register lines up with tick/phase.
  always_comb begin
    half_d = ({1'b0, active_div_d} + (CW+1)'(1)) >> 1;
    sq_d   = (state_d != StIdle) && ({1'b0, phase_d} < half_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sq_q <= 1'b0;
    end else begin
      sq_q <= sq_d;
    end
  end

  assign bus.sq_out = sq_q;
`endif

endmodule

// File: tb/tb_div_tick_scheduler.sv
// Scoreboard bench for div_tick_scheduler: directed steps push expected outputs,
// a monitor pops and compares one record per clock.
module tb_div_tick_scheduler;
  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  div_tick_scheduler_if #(.CW(CW)) bus ();

  div_tick_scheduler #(
    .CW          (CW),
    .DEFAULT_DIV (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic          tick;
    logic          busy;
    logic [CW-1:0] phase;
    logic          err;
    logic          rdy;
    logic          sq;
    logic          chk_sq;
    string         tag;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic step(input string tag, input logic st, input logic sp, input logic cv,
                      input int cd, input logic t, input logic b, input int ph,
                      input logic e, input logic r, input logic s = 1'b0,
                      input logic cs = 1'b0);
    exp_t x;
    @(negedge clk);
    bus.start     = st;
    bus.stop      = sp;
    bus.cfg_valid = cv;
    bus.cfg_div   = CW'(cd);
    x.tick   = t;
    x.busy   = b;
    x.phase  = CW'(ph);
    x.err    = e;
    x.rdy    = r;
    x.sq     = s;
    x.chk_sq = cs;
    x.tag    = tag;
    sb.push_back(x);
  endtask

  // n idle-input cycles while counting with divisor div from phase ph0.
  task automatic run(input string tag, input int n, input int div, input int ph0,
                     input logic rdy);
    int ph;
    for (int i = 1; i <= n; i++) begin
      ph = (ph0 + i) % div;
      step(tag, 1'b0, 1'b0, 1'b0, 0, ph == 0, 1'b1, ph, 1'b0, rdy);
    end
  endtask

  task automatic idle_step(input string tag, input logic st, input logic sp,
                           input logic cv, input int cd);
    step(tag, st, sp, cv, cd, 1'b0, 1'b0, 0, 1'b0, 1'b1);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk({x.tag, " tick"}, int'(bus.tick), int'(x.tick));
        chk({x.tag, " busy"}, int'(bus.busy), int'(x.busy));
        chk({x.tag, " phase"}, int'(bus.phase), int'(x.phase));
        chk({x.tag, " err"}, int'(bus.err), int'(x.err));
        chk({x.tag, " cfg_ready"}, int'(bus.cfg_ready), int'(x.rdy));
`ifdef SQUARE_OUT_EN
        if (x.chk_sq) chk({x.tag, " sq_out"}, int'(bus.sq_out), int'(x.sq));
`endif
      end
    end
  end

  initial begin : stim
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_div   = '0;
    repeat (2) @(negedge clk);
    chk("reset tick", int'(bus.tick), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset phase", int'(bus.phase), 0);
    chk("reset err", int'(bus.err), 0);
    chk("reset cfg_ready", int'(bus.cfg_ready), 1);
    reset = 1'b1;

    // Default divisor 3: ticks 1,4,7,10 cycles after start.
    step("t1 start", 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    run("t1 div3", 9, 3, 0, 1'b1);

    // IDLE config with start in the same cycle: first period uses 5.
    idle_step("t2 stop", 1'b0, 1'b1, 1'b0, 0);
    step("t2 start cfg5", 1'b1, 1'b0, 1'b1, 5, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    run("t2 div5", 10, 5, 0, 1'b1);

    // Divisor 6 offered at phase 1 is held until the div-3 wrap.
    idle_step("t3 stop", 1'b0, 1'b1, 1'b0, 0);
    step("t3 start cfg3", 1'b1, 1'b0, 1'b1, 3, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    run("t3 div3", 1, 3, 0, 1'b1);
    step("t3 cfg6", 1'b0, 1'b0, 1'b1, 6, 1'b0, 1'b1, 2, 1'b0, 1'b0);
    step("t3 wrap pend", 1'b0, 1'b0, 1'b1, 9, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    run("t3 div6", 6, 6, 0, 1'b1);

    // Illegal divisor: err pulse only, spacing unchanged.
    step("t4 cfg1", 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1, 1'b1, 1'b1);
    run("t4 div6", 5, 6, 1, 1'b1);

    // Stop on the PEND wrap cycle commits the pending divisor 4.
    step("t5 cfg4", 1'b0, 1'b0, 1'b1, 4, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    run("t5 pend", 4, 6, 1, 1'b0);
    idle_step("t5 stop", 1'b0, 1'b1, 1'b0, 0);
    idle_step("t5 start+stop", 1'b1, 1'b1, 1'b0, 0);
    step("t5 restart", 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    run("t5 div4", 4, 4, 0, 1'b1);

    // Stop with a concurrent legal transfer still installs the divisor.
    idle_step("t6 stop cfg7", 1'b0, 1'b1, 1'b1, 7);
    step("t6 start", 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    run("t6 div7", 9, 7, 0, 1'b1);

    // Asynchronous reset mid-period at phase 2.
    @(negedge clk);
    chk("t7 pre-reset phase", int'(bus.phase), 2);
    #2;
    reset = 1'b0;
    #1;
    chk("t7 async tick", int'(bus.tick), 0);
    chk("t7 async busy", int'(bus.busy), 0);
    chk("t7 async phase", int'(bus.phase), 0);
    chk("t7 async cfg_ready", int'(bus.cfg_ready), 1);
`ifdef SQUARE_OUT_EN
    chk("t7 async sq_out", int'(bus.sq_out), 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("t7 held tick", int'(bus.tick), 0);
    @(negedge clk);
    reset = 1'b1;
    idle_step("t7 exit", 1'b0, 1'b0, 1'b0, 0);
    step("t7 idle cfg0", 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 1'b1, 1'b1);

    // Divisor 4: tick 1,0,0,0 and square output 1,1,0,0.
    step("t8 start cfg4", 1'b1, 1'b0, 1'b1, 4, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    step("t8 p1", 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b1, 1'b1);
    step("t8 p2", 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 2, 1'b0, 1'b1, 1'b0, 1'b1);
    step("t8 p3", 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 3, 1'b0, 1'b1, 1'b0, 1'b1);
    step("t8 p0", 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    step("t8 p1b", 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b1, 1'b1);
    step("t8 stop", 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1);

    @(posedge clk);
    #2;
    chk("scoreboard drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
